debugger_mem_sequencer: RTL and testbench
=========================================

Name: debugger_mem_sequencer

Overview:
- Burst sequencer sitting between the debugger host link and the debugger port of the shared CPU/debugger memory multiplexer.
- Accepts one block read or write command (start address, byte count) and issues single-byte accesses on the debugger port.
- Issues accesses only in cycles where the CPU is not using memory, or while the CPU is halted. This prevents the debugger's precedence in the multiplexer from corrupting CPU accesses.
- Streams bytes in or out over ready/valid handshakes, with wait-timeout and abort handling.

Parameters:
- LEN_W, 8, width of i_cmd_length; a burst is 1..2^LEN_W bytes.
- WAIT_LIMIT, 1024, maximum consecutive cycles spent waiting for a free memory slot before the burst aborts with timeout (range 1..65535).

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  synchronous reset, active-high.
- i_cmd_valid  in  1  command valid.
- o_cmd_ready  out  1  command accepted when valid&&ready.
- i_cmd_rw  in  1  1=read, 0=write.
- i_cmd_address  in  16  start address.
- i_cmd_length  in  LEN_W  byte count minus one.
- i_wdata_valid  in  1  write byte valid.
- o_wdata_ready  out  1  write byte consumed.
- i_wdata  in  8  write byte.
- o_rdata_valid  out  1  read byte valid.
- i_rdata_ready  in  1  read byte accepted.
- o_rdata  out  8  read byte.
- i_cpu_en  in  1  CPU memory access this cycle.
- i_cpu_halted  in  1  CPU halted by debugger; slot always free.
- i_abort  in  1  abort current burst.
- o_dbg_en  out  1  debugger port enable.
- o_dbg_rw  out  1  debugger port rw (1=read, 0=write).
- o_dbg_address  out  16  debugger port address.
- o_dbg_data  out  8  debugger port write data.
- i_dbg_data  in  8  debugger port read data; valid the cycle after o_dbg_en.
- o_busy  out  1  burst in progress.
- o_done  out  1  one-cycle pulse at burst end.
- o_status  out  2  latched at o_done: 0=ok, 1=aborted, 2=timeout.

Behaviour:
- Clock and reset:
  - Single clock i_clk.
  - Reset is synchronous and active-high on i_reset.
  - Reset wins over every other input.
- Reset values:
  - state=IDLE.
  - o_cmd_ready=1 (combinational: state==IDLE).
  - o_wdata_ready, o_rdata_valid, o_dbg_en, o_busy, o_done = 0.
  - o_status=0, o_rdata=0, o_dbg_address=0, o_dbg_data=0, o_dbg_rw=1.
- Reset mid-burst: o_dbg_en drops at the next edge, the pending read byte is discarded, and no o_done pulse is produced.
- Free slot definition: free = i_cpu_halted || !i_cpu_en, sampled combinationally in the cycle the access would be issued.
- IDLE state:
  - On cmd_valid&&cmd_ready, latch rw, address and remaining = length.
  - Clear the wait counter.
  - Go to WAIT; o_busy=1 from the next cycle.
- WAIT state:
  - If free, and (rw=read, or i_wdata_valid), assert o_dbg_en this cycle. Drive o_dbg_address = current address, o_dbg_rw = rw, and o_dbg_data = i_wdata.
  - For a write, o_wdata_ready=1 in the same cycle, so the byte is consumed at that edge.
  - o_dbg_en is combinational from state and free. This means it is never high in a cycle where i_cpu_en=1 and i_cpu_halted=0.
  - After issuing, go to CAPTURE for a read, or to NEXT logic for a write.
  - The wait counter increments on each WAIT cycle without issue, including write-data starvation. It is cleared on every issue.
  - Reaching WAIT_LIMIT means finish with status 2.
- CAPTURE state (read only):
  - Register i_dbg_data into o_rdata.
  - Set o_rdata_valid=1 and go to DRAIN.
- DRAIN state:
  - Hold o_rdata stable while o_rdata_valid && !i_rdata_ready.
  - On acceptance, clear o_rdata_valid and apply NEXT logic.
  - Single-entry buffer: there is no new access until the byte is accepted.
  - DRAIN is not subject to the timeout.
- NEXT logic:
  - If remaining==0, finish with status 0.
  - Otherwise remaining -= 1 and address += 1 modulo 2^16 (0xFFFF wraps to 0x0000), then return to WAIT.
- Write burst throughput: one byte per cycle when the slot is free and data is available. Read burst throughput: one byte per 3 cycles maximum (issue, capture, accept).
- Finish:
  - Go to IDLE, pulse o_done for 1 cycle and latch o_status.
  - o_busy=0 in the o_done cycle.
  - o_cmd_ready=1 in the o_done cycle; a new command may be accepted then.
- Abort:
  - i_abort in any non-IDLE state finishes with status 1 at the next edge.
  - The access in the abort cycle is suppressed (o_dbg_en=0, o_wdata_ready=0).
  - A pending o_rdata_valid is cleared.
  - i_abort in IDLE is ignored.
- Priority within a cycle: reset > abort > timeout > issue.
- Write data presented while the sequencer is not in WAIT is never consumed.

Test Plan:
- Read burst: cmd rw=1, addr 0x0200, length 3, CPU idle, rdata_ready=1 -> o_dbg_en pulses at addresses 0x0200..0x0203. Four o_rdata bytes match memory. o_done with status 0 after the 4th byte.
- Write burst with CPU contention: addr 0x0010, length 1, i_cpu_en toggling 1/0 -> o_dbg_en is never high while i_cpu_en=1. Bytes 0xAA, 0xBB are written to 0x0010 and 0x0011. Status 0.
- Halted CPU: i_cpu_halted=1, i_cpu_en=1 constantly, write length 255 with wdata always valid -> 256 consecutive o_dbg_en cycles. o_done in the cycle after the last write.
- Wrap and backpressure: read addr 0xFFFE, length 2, rdata_ready low 5 cycles per byte -> addresses 0xFFFE, 0xFFFF, 0x0000. o_rdata is held stable while valid and not ready.
- Timeout: WAIT_LIMIT=8, i_cpu_en=1 and i_cpu_halted=0 forever, read command -> o_done with status 2 after 8 wait cycles. Zero o_dbg_en pulses.
- Abort and reset mid-burst: abort during the 3rd byte of a write of 6 -> o_done with status 1 and exactly 2 bytes written. Reset asserted mid-read -> all outputs at reset values next cycle and no o_done pulse.

Source files
------------

// File: rtl/debugger_mem_sequencer.sv
// Burst sequencer for the debugger port of the shared CPU/debugger memory mux.
// Turns one block read/write command into single-byte accesses issued only in free memory slots.
module debugger_mem_sequencer #(
    parameter int LEN_W      = 8,
    parameter int WAIT_LIMIT = 1024
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_cmd_valid,
    output logic             o_cmd_ready,
    input  logic             i_cmd_rw,
    input  logic [15:0]      i_cmd_address,
    input  logic [LEN_W-1:0] i_cmd_length,
    input  logic             i_wdata_valid,
    output logic             o_wdata_ready,
    input  logic [7:0]       i_wdata,
    output logic             o_rdata_valid,
    input  logic             i_rdata_ready,
    output logic [7:0]       o_rdata,
    input  logic             i_cpu_en,
    input  logic             i_cpu_halted,
    input  logic             i_abort,
    output logic             o_dbg_en,
    output logic             o_dbg_rw,
    output logic [15:0]      o_dbg_address,
    output logic [7:0]       o_dbg_data,
    input  logic [7:0]       i_dbg_data,
    output logic             o_busy,
    output logic             o_done,
    output logic [1:0]       o_status
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_CAPTURE,
        S_DRAIN
    } state_t;

    localparam logic [1:0]  STATUS_OK      = 2'd0;
    localparam logic [1:0]  STATUS_ABORT   = 2'd1;
    localparam logic [1:0]  STATUS_TIMEOUT = 2'd2;
    localparam logic [15:0] WAIT_LAST      = 16'(WAIT_LIMIT - 1);

    state_t           state;
    logic             rw;
    logic [15:0]      address;
    logic [LEN_W-1:0] remaining;
    logic [15:0]      wait_cnt;

    logic       slot_free;
    logic       issue;
    logic       last_byte;
    logic       drain_accept;
    logic       finish;
    logic [1:0] finish_status;

    // The debugger wins arbitration in the mux, so it may only go when the CPU is idle or halted.
    assign slot_free    = i_cpu_halted || !i_cpu_en;
    assign issue        = (state == S_WAIT) && !i_abort && slot_free && (rw || i_wdata_valid);
    assign last_byte    = (remaining == '0);
    assign drain_accept = (state == S_DRAIN) && i_rdata_ready;

    assign o_cmd_ready   = (state == S_IDLE);
    assign o_dbg_en      = issue;
    assign o_wdata_ready = issue && !rw;
    assign o_dbg_rw      = rw;
    assign o_dbg_address = address;
    assign o_dbg_data    = (state == S_WAIT && !rw) ? i_wdata : 8'h00;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        finish        = 1'b0;
        finish_status = STATUS_OK;
        if (state != S_IDLE && i_abort) begin
            finish        = 1'b1;
            finish_status = STATUS_ABORT;
        end else if (state == S_WAIT && !issue && wait_cnt == WAIT_LAST) begin
            finish        = 1'b1;
            finish_status = STATUS_TIMEOUT;
        end else if (((issue && !rw) || drain_accept) && last_byte) begin
            finish        = 1'b1;
            finish_status = STATUS_OK;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state         <= S_IDLE;
            rw            <= 1'b1;
            address       <= 16'h0000;
            remaining     <= '0;
            wait_cnt      <= 16'h0000;
            o_rdata       <= 8'h00;
            o_rdata_valid <= 1'b0;
            o_busy        <= 1'b0;
            o_done        <= 1'b0;
            o_status      <= STATUS_OK;
        end else begin
            o_done <= finish;
            if (finish) begin
                state         <= S_IDLE;
                o_busy        <= 1'b0;
                o_rdata_valid <= 1'b0;
                o_status      <= finish_status;
            end else begin
                unique case (state)
                    S_IDLE: begin
                        if (i_cmd_valid) begin
                            rw        <= i_cmd_rw;
                            address   <= i_cmd_address;
                            remaining <= i_cmd_length;
                            wait_cnt  <= 16'h0000;
                            o_busy    <= 1'b1;
                            state     <= S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        if (issue) begin
                            wait_cnt <= 16'h0000;
                            if (rw) begin
                                state <= S_CAPTURE;
                            end else begin
                                remaining <= remaining - LEN_W'(1);
                                address   <= address + 16'd1;
                            end
                        end else begin
                            wait_cnt <= wait_cnt + 16'd1;
                        end
                    end
                    S_CAPTURE: begin
                        o_rdata       <= i_dbg_data;
                        o_rdata_valid <= 1'b1;
                        state         <= S_DRAIN;
                    end
                    S_DRAIN: begin
                        // Single-entry buffer: the next read is not issued until this byte leaves.
                        if (i_rdata_ready) begin
                            o_rdata_valid <= 1'b0;
                            remaining     <= remaining - LEN_W'(1);
                            address       <= address + 16'd1;
                            state         <= S_WAIT;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_debugger_mem_sequencer.sv
// Scoreboard bench for debugger_mem_sequencer: a byte-array memory model answers the debugger port,
// expected accesses, read bytes and completion statuses are queued when stimulus is driven.
module tb_debugger_mem_sequencer;

    localparam int LEN_W      = 8;
    localparam int WAIT_LIMIT = 8;

    typedef struct packed {
        logic        rw;
        logic [15:0] addr;
        logic [7:0]  data;
    } acc_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_valid, cmd_ready, cmd_rw;
    logic [15:0]      cmd_address;
    logic [LEN_W-1:0] cmd_length;
    logic             wdata_valid, wdata_ready;
    logic [7:0]       wdata;
    logic             rdata_valid, rdata_ready;
    logic [7:0]       rdata;
    logic             cpu_en, cpu_halted, abort;
    logic             dbg_en, dbg_rw;
    logic [15:0]      dbg_address;
    logic [7:0]       dbg_data, dbg_rdata;
    logic             busy, done;
    logic [1:0]       status;

    debugger_mem_sequencer #(.LEN_W(LEN_W), .WAIT_LIMIT(WAIT_LIMIT)) dut (
        .i_clk(clk), .i_reset(rst),
        .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_rw(cmd_rw),
        .i_cmd_address(cmd_address), .i_cmd_length(cmd_length),
        .i_wdata_valid(wdata_valid), .o_wdata_ready(wdata_ready), .i_wdata(wdata),
        .o_rdata_valid(rdata_valid), .i_rdata_ready(rdata_ready), .o_rdata(rdata),
        .i_cpu_en(cpu_en), .i_cpu_halted(cpu_halted), .i_abort(abort),
        .o_dbg_en(dbg_en), .o_dbg_rw(dbg_rw), .o_dbg_address(dbg_address),
        .o_dbg_data(dbg_data), .i_dbg_data(dbg_rdata),
        .o_busy(busy), .o_done(done), .o_status(status)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] pat(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    function automatic acc_t mk(input logic r, input logic [15:0] a, input logic [7:0] d);
        acc_t t;
        t.rw = r; t.addr = a; t.data = d;
        return t;
    endfunction

    logic [7:0] mem [0:65535];
    acc_t       exp_acc[$];
    logic [7:0] exp_rd[$];
    logic [1:0] exp_done[$];
    logic [7:0] wq[$];

    // Monitor state
    int         cyc = 0, n_acc = 0, n_done = 0, busy_cnt = 0;
    int         streak = 0, max_streak = 0, last_en_cyc = 0, done_cyc = 0;
    logic       consumed = 1'b0, prev_hold = 1'b0, rd_pending = 1'b0;
    logic [7:0] prev_rdata, rd_byte, got_b;
    logic [1:0] got_s;
    acc_t       mon_a;

    // Control flags for background drivers
    logic feed_en = 1'b0, cpu_toggle = 1'b0, bp_en = 1'b0;
    int   bp_cnt = 0;

    always @(negedge clk) begin
        cyc++;
        consumed = 1'b0;
        if (rst) begin
            prev_hold = 1'b0;
            streak    = 0;
        end else begin
            if (busy) busy_cnt++;
            if (dbg_en) begin
                n_acc++;
                streak++;
                if (streak > max_streak) max_streak = streak;
                last_en_cyc = cyc;
                check("slot_free", {31'd0, cpu_en && !cpu_halted}, 0);
                if (exp_acc.size() == 0) begin
                    check("unexpected_access", 1, 0);
                end else begin
                    mon_a = exp_acc.pop_front();
                    check("acc_rw", {31'd0, dbg_rw}, {31'd0, mon_a.rw});
                    check("acc_addr", {16'd0, dbg_address}, {16'd0, mon_a.addr});
                    if (!mon_a.rw) check("wr_data", {24'd0, dbg_data}, {24'd0, mon_a.data});
                end
                if (dbg_rw) begin
                    rd_pending = 1'b1;
                    rd_byte    = mem[dbg_address];
                end else begin
                    mem[dbg_address] = dbg_data;
                end
            end else begin
                streak = 0;
            end
            if (wdata_ready) begin
                check("wready_with_en", {31'd0, dbg_en}, 1);
                consumed = wdata_valid;
            end
            if (prev_hold) begin
                check("rdata_hold_valid", {31'd0, rdata_valid}, 1);
                check("rdata_hold", {24'd0, rdata}, {24'd0, prev_rdata});
            end
            if (rdata_valid && rdata_ready) begin
                if (exp_rd.size() == 0) begin
                    check("unexpected_rdata", 1, 0);
                end else begin
                    got_b = exp_rd.pop_front();
                    check("rdata", {24'd0, rdata}, {24'd0, got_b});
                end
            end
            prev_hold  = rdata_valid && !rdata_ready;
            prev_rdata = rdata;
            if (done) begin
                n_done++;
                done_cyc = cyc;
                check("busy_at_done", {31'd0, busy}, 0);
                check("cmd_ready_at_done", {31'd0, cmd_ready}, 1);
                if (exp_done.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    got_s = exp_done.pop_front();
                    check("status", {30'd0, status}, {30'd0, got_s});
                end
            end
        end
    end

    // Memory read data appears in the cycle after the access.
    always @(posedge clk) begin
        #1;
        if (rd_pending) begin
            dbg_rdata  = rd_byte;
            rd_pending = 1'b0;
        end else begin
            dbg_rdata = 8'($urandom);
        end
    end

    always @(posedge clk) begin
        #1;
        if (consumed && wq.size() > 0) void'(wq.pop_front());
        wdata_valid = feed_en && (wq.size() > 0);
        wdata       = (wq.size() > 0) ? wq[0] : 8'h00;
        if (cpu_toggle) cpu_en = ~cpu_en;
        if (bp_en) begin
            if (rdata_valid && !rdata_ready) begin
                bp_cnt++;
                if (bp_cnt > 5) rdata_ready = 1'b1;
            end else begin
                rdata_ready = 1'b0;
                bp_cnt      = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send_cmd(input logic r, input logic [15:0] a, input int len_m1);
        int n;
        n = 0;
        cmd_valid   = 1'b1;
        cmd_rw      = r;
        cmd_address = a;
        cmd_length  = LEN_W'(len_m1);
        while (!cmd_ready && n < 50) begin
            tick();
            n++;
        end
        check("cmd_ready_seen", {31'd0, cmd_ready}, 1);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int start, n;
        start = n_done;
        n     = 0;
        while (n_done == start && n < budget) begin
            tick();
            n++;
        end
        check({tag, "_done_seen"}, {31'd0, n_done != start}, 1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_cmd_ready"}, {31'd0, cmd_ready}, 1);
        check({tag, "_wdata_ready"}, {31'd0, wdata_ready}, 0);
        check({tag, "_rdata_valid"}, {31'd0, rdata_valid}, 0);
        check({tag, "_dbg_en"}, {31'd0, dbg_en}, 0);
        check({tag, "_busy"}, {31'd0, busy}, 0);
        check({tag, "_done"}, {31'd0, done}, 0);
        check({tag, "_status"}, {30'd0, status}, 0);
        check({tag, "_rdata"}, {24'd0, rdata}, 0);
        check({tag, "_dbg_address"}, {16'd0, dbg_address}, 0);
        check({tag, "_dbg_data"}, {24'd0, dbg_data}, 0);
        check({tag, "_dbg_rw"}, {31'd0, dbg_rw}, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_acc, base_done;
        for (int i = 0; i < 65536; i++) mem[i] = pat(16'(i));
        rst = 1'b1; cmd_valid = 1'b0; cmd_rw = 1'b0; cmd_address = 16'h0; cmd_length = '0;
        wdata_valid = 1'b0; wdata = 8'hC3; rdata_ready = 1'b1; cpu_en = 1'b0;
        cpu_halted = 1'b0; abort = 1'b0; dbg_rdata = 8'h00;

        // Reset values, with noisy inputs held during reset
        cmd_valid = 1'b1; abort = 1'b1;
        tick();
        tick();
        check_reset_values("reset");
        cmd_valid = 1'b0; abort = 1'b0; rst = 1'b0;
        tick();

        // Abort while idle is ignored
        base_done = n_done;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tick();
        tick();
        check("idle_abort_no_done", n_done, base_done);
        check("idle_abort_busy", {31'd0, busy}, 0);

        // Read burst 0x0200..0x0203
        base_acc = n_acc;
        for (int i = 0; i < 4; i++) begin
            exp_acc.push_back(mk(1'b1, 16'h0200 + 16'(i), 8'h00));
            exp_rd.push_back(pat(16'h0200 + 16'(i)));
        end
        exp_done.push_back(2'd0);
        send_cmd(1'b1, 16'h0200, 3);
        check("read_busy", {31'd0, busy}, 1);
        wait_done("read", 100);
        check("read_accesses", n_acc - base_acc, 4);

        // Write burst with CPU contention
        base_acc = n_acc;
        wq.push_back(8'hAA); wq.push_back(8'hBB);
        exp_acc.push_back(mk(1'b0, 16'h0010, 8'hAA));
        exp_acc.push_back(mk(1'b0, 16'h0011, 8'hBB));
        exp_done.push_back(2'd0);
        feed_en = 1'b1; cpu_toggle = 1'b1;
        send_cmd(1'b0, 16'h0010, 1);
        wait_done("contention", 100);
        cpu_toggle = 1'b0; cpu_en = 1'b0;
        check("contention_accesses", n_acc - base_acc, 2);
        check("contention_mem0", {24'd0, mem[16'h0010]}, 32'hAA);
        check("contention_mem1", {24'd0, mem[16'h0011]}, 32'hBB);
        tick();

        // Halted CPU, 256-byte write at full rate
        base_acc = n_acc;
        cpu_halted = 1'b1; cpu_en = 1'b1; max_streak = 0;
        for (int i = 0; i < 256; i++) begin
            wq.push_back(8'(i * 7 + 3));
            exp_acc.push_back(mk(1'b0, 16'h1000 + 16'(i), 8'(i * 7 + 3)));
        end
        exp_done.push_back(2'd0);
        send_cmd(1'b0, 16'h1000, 255);
        wait_done("halted", 400);
        check("halted_accesses", n_acc - base_acc, 256);
        check("halted_streak", max_streak, 256);
        check("halted_done_latency", done_cyc - last_en_cyc, 1);
        check("halted_mem_last", {24'd0, mem[16'h10FF]}, {24'd0, 8'(255 * 7 + 3)});
        cpu_halted = 1'b0; cpu_en = 1'b0; feed_en = 1'b0;
        tick();

        // Read with address wrap and backpressure
        base_acc = n_acc;
        bp_en = 1'b1; rdata_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            exp_acc.push_back(mk(1'b1, 16'hFFFE + 16'(i), 8'h00));
            exp_rd.push_back(pat(16'hFFFE + 16'(i)));
        end
        exp_done.push_back(2'd0);
        send_cmd(1'b1, 16'hFFFE, 2);
        wait_done("wrap", 200);
        check("wrap_accesses", n_acc - base_acc, 3);
        bp_en = 1'b0; rdata_ready = 1'b1;
        tick();

        // Timeout: CPU owns every slot
        base_acc = n_acc;
        cpu_en = 1'b1; busy_cnt = 0;
        exp_done.push_back(2'd2);
        send_cmd(1'b1, 16'h4000, 0);
        wait_done("timeout", 100);
        check("timeout_wait_cycles", busy_cnt, WAIT_LIMIT);
        check("timeout_accesses", n_acc - base_acc, 0);
        cpu_en = 1'b0;
        tick();

        // Abort on the 3rd byte of a 6-byte write
        base_acc = n_acc;
        for (int i = 0; i < 6; i++) wq.push_back(8'h60 + 8'(i));
        exp_acc.push_back(mk(1'b0, 16'h3000, 8'h60));
        exp_acc.push_back(mk(1'b0, 16'h3001, 8'h61));
        exp_done.push_back(2'd1);
        feed_en = 1'b1;
        send_cmd(1'b0, 16'h3000, 5);
        for (int n = 0; n < 50 && n_acc < base_acc + 2; n++) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        wait_done("abort", 20);
        check("abort_accesses", n_acc - base_acc, 2);
        check("abort_mem_untouched", {24'd0, mem[16'h3002]}, {24'd0, pat(16'h3002)});
        feed_en = 1'b0;
        wq.delete();
        tick();

        // Reset in the middle of a read burst
        base_acc  = n_acc;
        base_done = n_done;
        rdata_ready = 1'b0;
        for (int i = 0; i < 4; i++) exp_acc.push_back(mk(1'b1, 16'h0300 + 16'(i), 8'h00));
        send_cmd(1'b1, 16'h0300, 3);
        for (int n = 0; n < 20 && !rdata_valid; n++) tick();
        check("midread_valid", {31'd0, rdata_valid}, 1);
        rst = 1'b1;
        tick();
        check_reset_values("midreset");
        rst = 1'b0;
        exp_acc.delete();
        exp_rd.delete();
        for (int i = 0; i < 6; i++) tick();
        check("midreset_no_done", n_done, base_done);
        check("midreset_accesses", n_acc - base_acc, 1);

        check("exp_acc_empty", exp_acc.size(), 0);
        check("exp_done_empty", exp_done.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
